// File: rtl/fft_pkg.sv
// Shared types and helpers for the 4-point FFT input buffer.
// Holds the complex sample type, the frame type and the 2-bit bit-reverse helper.
package fft_pkg;

    localparam int N_PTS  = 4;
    localparam int CPLX_W = 16;

    typedef struct packed {
        logic [CPLX_W-1:0] re;
        logic [CPLX_W-1:0] im;
    } cplx_t;

    typedef cplx_t frame_t [N_PTS];

    // Reverse the two bits of a slot index (0,1,2,3 -> 0,2,1,3).
    function automatic logic [1:0] bitrev2(input logic [1:0] k);
        return {k[0], k[1]};
    endfunction

endpackage

// File: rtl/fft4_in_bank.sv
// One 4-entry complex register bank: a single slot is written per cycle when
// we is high; all four slots are always visible on dout.
module fft4_in_bank
    import fft_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [1:0] slot,
    input  cplx_t      din,
    output frame_t     dout
);

    cplx_t bank_r [N_PTS];

    // Slot storage: cleared on reset, one slot written per accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_PTS; k++) begin
                bank_r[k] <= '0;
            end
        end else if (we) begin
            bank_r[slot] <= din;
        end
    end

    assign dout = bank_r;

endmodule

// File: rtl/fft4_in_buffer.sv
// Ping-pong input buffer for the 4-point FFT: gathers serial complex samples
// into 4-sample frames and presents each frame in parallel with valid/ready.
// Optional build macro FFT_IN_BITREV_EN: store samples in bit-reversed slot
// order (serial 0,1,2,3 lands in X0,X2,X1,X3); natural order otherwise.
module fft4_in_buffer
    import fft_pkg::*;
#(
    parameter int DATA_W = CPLX_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] X0_Real,
    output logic [DATA_W-1:0] X0_Im,
    output logic [DATA_W-1:0] X1_Real,
    output logic [DATA_W-1:0] X1_Im,
    output logic [DATA_W-1:0] X2_Real,
    output logic [DATA_W-1:0] X2_Im,
    output logic [DATA_W-1:0] X3_Real,
    output logic [DATA_W-1:0] X3_Im,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic [1:0]       full_r;
    logic             wr_bank_r;
    logic             rd_bank_r;
    logic [1:0]       wr_idx_r;
    logic [CNT_W-1:0] drop_cnt_r;

    logic [1:0]       full_nxt_s;
    logic             wr_bank_nxt_s;
    logic             rd_bank_nxt_s;
    logic [1:0]       wr_idx_nxt_s;
    logic [CNT_W-1:0] drop_cnt_nxt_s;

    logic             accept_s;
    logic             release_s;
    logic             restart_s;
    logic [1:0]       slot_idx_s;
    logic [1:0]       slot_s;
    cplx_t            sample_s;
    frame_t           bank0_s;
    frame_t           bank1_s;
    frame_t           rd_frame_s;

    // Handshake: ready depends only on registered full flags, so a release
    // frees the bank for the following cycle, never the same one.
    assign in_ready  = !rst && !full_r[wr_bank_r];
    assign out_valid = full_r[rd_bank_r];
    assign accept_s  = in_valid && in_ready;
    assign release_s = out_valid && out_ready;
    assign restart_s = in_sof && (wr_idx_r != 2'd0);

    assign sample_s.re = in_re;
    assign sample_s.im = in_im;

    // Slot selection: a restarting sample always goes to position 0.
    always_comb begin
        slot_idx_s = wr_idx_r;
        if (restart_s) begin
            slot_idx_s = 2'd0;
        end else begin
            slot_idx_s = wr_idx_r;
        end
`ifdef FFT_IN_BITREV_EN
        slot_s = bitrev2(slot_idx_s);
`else
        slot_s = slot_idx_s;
`endif
    end

    // Next-state for pointers, full flags and drop counter; fill and release
    // always target different banks so both may apply in one cycle.
    always_comb begin
        full_nxt_s     = full_r;
        wr_bank_nxt_s  = wr_bank_r;
        rd_bank_nxt_s  = rd_bank_r;
        wr_idx_nxt_s   = wr_idx_r;
        drop_cnt_nxt_s = drop_cnt_r;
        if (release_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
            rd_bank_nxt_s         = ~rd_bank_r;
        end else begin
            rd_bank_nxt_s = rd_bank_r;
        end
        if (accept_s) begin
            if (restart_s) begin
                wr_idx_nxt_s = 2'd1;
                if (drop_cnt_r != {CNT_W{1'b1}}) begin
                    drop_cnt_nxt_s = drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    drop_cnt_nxt_s = drop_cnt_r;
                end
            end else if (wr_idx_r == 2'd3) begin
                full_nxt_s[wr_bank_r] = 1'b1;
                wr_bank_nxt_s         = ~wr_bank_r;
                wr_idx_nxt_s          = 2'd0;
            end else begin
                wr_idx_nxt_s = wr_idx_r + 2'd1;
            end
        end else begin
            wr_idx_nxt_s = wr_idx_r;
        end
    end

    // Control state register; reset discards partial and pending frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r     <= 2'b00;
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b0;
            wr_idx_r   <= 2'd0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            full_r     <= full_nxt_s;
            wr_bank_r  <= wr_bank_nxt_s;
            rd_bank_r  <= rd_bank_nxt_s;
            wr_idx_r   <= wr_idx_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    fft4_in_bank u_bank0 (
        .clk  (clk),
        .rst  (rst),
        .we   (accept_s && (wr_bank_r == 1'b0)),
        .slot (slot_s),
        .din  (sample_s),
        .dout (bank0_s)
    );

    fft4_in_bank u_bank1 (
        .clk  (clk),
        .rst  (rst),
        .we   (accept_s && (wr_bank_r == 1'b1)),
        .slot (slot_s),
        .din  (sample_s),
        .dout (bank1_s)
    );

    // Output mux: present the bank the consumer reads next.
    always_comb begin
        if (rd_bank_r) begin
            rd_frame_s = bank1_s;
        end else begin
            rd_frame_s = bank0_s;
        end
    end

    assign X0_Real  = rd_frame_s[0].re;
    assign X0_Im    = rd_frame_s[0].im;
    assign X1_Real  = rd_frame_s[1].re;
    assign X1_Im    = rd_frame_s[1].im;
    assign X2_Real  = rd_frame_s[2].re;
    assign X2_Im    = rd_frame_s[2].im;
    assign X3_Real  = rd_frame_s[3].re;
    assign X3_Im    = rd_frame_s[3].im;
    assign drop_cnt = drop_cnt_r;

endmodule
